draw_card: RTL and testbench
============================

# draw_card

Draws one playing-card bitmap over the incoming VGA stream. It sits between the timing/background chain and the card bitmap ROM. It converts the current pixel coordinates into a ROM address, takes back the ROM pixel one cycle later, and muxes it over the background with the timing signals delayed to match. The card position and visibility are double-buffered and change only at the start of vertical blanking, so a card never tears mid-frame.

## Interface
Parameters:
- ADDR_WIDTH, 13, ROM address width; must satisfy CARD_W*CARD_H <= 2**ADDR_WIDTH
- DATA_WIDTH, 12, RGB444 pixel width
- CARD_W, 64, card width in pixels
- CARD_H, 96, card height in pixels

Ports:
- clk  in  1  pixel clock, posedge active
- rst_n  in  1  reset, asynchronous, active-low
- hcount_in, vcount_in  in  11 each  current pixel coordinates
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  timing
- rgb_in  in  DATA_WIDTH  background pixel
- xpos, ypos  in  11 each  requested card top-left corner
- card_en  in  1  requested visibility
- pos_valid  in  1  request strobe
- pos_ready  out  1  high when no update is pending
- rom_addr  out  ADDR_WIDTH  address to the bitmap ROM (registered)
- rom_pixel  in  DATA_WIDTH  ROM data, valid 1 cycle after rom_addr
- hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out  out  as inputs  delayed and overlaid stream

## Operation
- Shadow registers: when pos_valid && pos_ready, capture xpos, ypos and card_en into shadow registers; set pending; pos_ready drops the next cycle.
- Commit: on the first cycle of vblnk_in rising (vblnk_in=1, previous=0) with pending set, copy the shadow registers into the active registers and clear pending.
- Handshake then commit on the same cycle: if pending=0, the request is captured and commits at the next frame's vblank edge.
- pos_valid while pos_ready=0 is ignored; no overwrite.
- Hit test, stage 1: hit = active_en && hcount_in in [ax, ax+CARD_W) && vcount_in in [ay, ay+CARD_H). Compares are unsigned at 12 bits so ax+CARD_W cannot wrap.
- Address, stage 1: rom_addr = (vcount_in-ay)*CARD_W + (hcount_in-ax), truncated to ADDR_WIDTH. When hit=0, rom_addr is 0.
- Stage 2: rom_pixel is returned by the ROM. The hit flag, timing and rgb_in are carried through a second register.
- Output stage: rgb_out = rom_pixel if (hit && !hblnk && !vblnk) else delayed rgb_in.
- Card partly off-screen (ax+CARD_W > 1024): draw only the visible part; no wrap to the left edge.

## Timing
- Latency: inputs sampled at edge k appear on every *_out at edge k+3. rom_addr is valid at edge k+1, rom_pixel is expected at edge k+2, and all three stages are pipelined.
- Throughput: one pixel per clock, no stalls.
- Reset (async assert, sync deassert handled upstream):
  - All *_out = 0, rom_addr = 0
  - Active/shadow position = 0, active_en = 0, pending = 0, pos_ready = 1
- Reset mid-frame: the pipeline flushes to zeros and the card stays hidden until a new request commits.

## Configuration
- DRAW_CARD_TRANSPARENT_EN defined: a ROM pixel equal to TRANSPARENT_COLOR is treated as hit=0 at the output stage, so the background shows through rounded card corners.
- Not defined: every pixel inside the card rectangle is drawn from the ROM, including key-coloured ones.

## Structure
- card_pkg:
  - CARD_W and CARD_H defaults
  - TRANSPARENT_COLOR = 12'hF0F
  - typedef vga_t, a struct of hcount, vcount, hsync, vsync, hblnk, vblnk, rgb, reused for the delay registers
- Sub-module vga_delay: parameterised N-stage register pipe for vga_t with async active-low reset, instantiated with N=3 for the timing path.

## Test plan
- Reset: assert rst_n=0 mid-line → all outputs 0 and pos_ready=1 immediately; after release, rgb_out equals rgb_in delayed 3 cycles.
- Commit: request x=100, y=50, en=1 mid-frame → no card this frame, pos_ready=0. After the vblnk rise, pos_ready=1, and next frame pixel (100,50) gives rom_addr=0, (163,50) gives 63, and (100,51) gives 64.
- Edges: pixel (164,50) and (100,146) → rgb_out = background. Pixel (163,145) → rom_addr=6143.
- Blocked request: second pos_valid while pending → ignored, and the first position is the one displayed.
- Transparency with the macro defined: rom_pixel=12'hF0F inside the card → rgb_out=rgb_in. Without the macro → rgb_out=12'hF0F.
- Edge overlap: x=1000 → only columns 1000..1023 are drawn, and column 0 of the next line is unaffected.

Source files
------------

// File: rtl/draw_card_pkg.sv
// draw_card_pkg: shared definitions for the card overlay block.
//   DEF_CARD_W / DEF_CARD_H : default card bitmap size in pixels
//   VGA_DATA_W              : RGB444 pixel width carried in vga_t
//   TRANSPARENT_COLOR       : key colour used when DRAW_CARD_TRANSPARENT_EN is defined
//   vga_t                   : one pixel of the VGA stream (timing + colour)
//   in_span()               : unsigned half-open range test [start, start+len)
package draw_card_pkg;

  localparam int unsigned DEF_CARD_W = 64;
  localparam int unsigned DEF_CARD_H = 96;
  localparam int unsigned VGA_DATA_W = 12;

  localparam logic [VGA_DATA_W-1:0] TRANSPARENT_COLOR = 12'hF0F;

  typedef struct packed {
    logic [10:0]           hcount;
    logic [10:0]           vcount;
    logic                  hsync;
    logic                  vsync;
    logic                  hblnk;
    logic                  vblnk;
    logic [VGA_DATA_W-1:0] rgb;
  } vga_t;

  // 12-bit operands so start+len cannot wrap for 11-bit coordinates.
  function automatic logic in_span(input logic [11:0] p,
                                   input logic [11:0] start,
                                   input logic [11:0] len);
    return (p >= start) && (p < (start + len));
  endfunction

endpackage

// File: rtl/draw_card_if.sv
// draw_card_if: card position request handshake.
//   xpos, ypos : requested card top-left corner
//   card_en    : requested visibility
//   pos_valid  : request strobe (requester -> draw_card)
//   pos_ready  : high when no update is pending (draw_card -> requester)
// Modports: master = requester, slave = draw_card.
interface draw_card_if;
  logic [10:0] xpos;
  logic [10:0] ypos;
  logic        card_en;
  logic        pos_valid;
  logic        pos_ready;

  modport master (output xpos, ypos, card_en, pos_valid, input pos_ready);
  modport slave  (input xpos, ypos, card_en, pos_valid, output pos_ready);
endinterface

// File: rtl/draw_card_vga_delay.sv
// vga_delay: N-stage register pipe for vga_t, async active-low reset.
//   clk, rst_n : pixel clock, reset
//   vga_i      : stream in
//   vga_o      : stream delayed by N clocks
module vga_delay
  import draw_card_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  vga_t vga_i,
  output vga_t vga_o
);

  vga_t stage_q [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= vga_i;
      for (int unsigned i = 1; i < N; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign vga_o = stage_q[N-1];

endmodule

// File: rtl/draw_card.sv
// draw_card: overlays one card bitmap on the VGA stream.
//   clk, rst_n             : pixel clock, async active-low reset
//   hcount_in..rgb_in      : incoming stream
//   pos (draw_card_if)     : double-buffered position/visibility request
//   rom_addr / rom_pixel   : bitmap ROM, data valid one cycle after address
//   hcount_out..rgb_out    : stream delayed 3 clocks with card overlaid
// Optional feature: DRAW_CARD_TRANSPARENT_EN makes TRANSPARENT_COLOR pixels
// show the background.
module draw_card
  import draw_card_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned CARD_W     = DEF_CARD_W,
  parameter int unsigned CARD_H     = DEF_CARD_H
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [10:0]           hcount_in,
  input  logic [10:0]           vcount_in,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  input  logic                  hblnk_in,
  input  logic                  vblnk_in,
  input  logic [DATA_WIDTH-1:0] rgb_in,
  draw_card_if.slave            pos,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_pixel,
  output logic [10:0]           hcount_out,
  output logic [10:0]           vcount_out,
  output logic                  hsync_out,
  output logic                  vsync_out,
  output logic                  hblnk_out,
  output logic                  vblnk_out,
  output logic [DATA_WIDTH-1:0] rgb_out
);

  logic [10:0] sh_x_q, sh_x_d, sh_y_q, sh_y_d;
  logic        sh_en_q, sh_en_d, pend_q, pend_d;
  logic [10:0] act_x_q, act_x_d, act_y_q, act_y_d;
  logic        act_en_q, act_en_d;
  logic        vblnk_prev_q;

  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic                  hit_d, hit1_q, hit2_q, hit3_q;
  logic [DATA_WIDTH-1:0] pixel_q;
  logic [10:0]           dx, dy;
  logic                  key_hit, draw;
  vga_t                  vga_in, vga_dly;

  // A handshake is only possible with pend_q=0, and commit requires
  // pend_q=1, so the two branches never act in the same cycle.
  always_comb begin
    sh_x_d   = sh_x_q;
    sh_y_d   = sh_y_q;
    sh_en_d  = sh_en_q;
    pend_d   = pend_q;
    act_x_d  = act_x_q;
    act_y_d  = act_y_q;
    act_en_d = act_en_q;
    if (vblnk_in && !vblnk_prev_q && pend_q) begin
      act_x_d  = sh_x_q;
      act_y_d  = sh_y_q;
      act_en_d = sh_en_q;
      pend_d   = 1'b0;
    end
    if (pos.pos_valid && !pend_q) begin
      sh_x_d  = pos.xpos;
      sh_y_d  = pos.ypos;
      sh_en_d = pos.card_en;
      pend_d  = 1'b1;
    end
  end

  assign pos.pos_ready = ~pend_q;

  // Stage 1: hit test and ROM address from the current coordinates.
  always_comb begin
    hit_d = act_en_q
         && in_span({1'b0, hcount_in}, {1'b0, act_x_q}, 12'(CARD_W))
         && in_span({1'b0, vcount_in}, {1'b0, act_y_q}, 12'(CARD_H));
    dx = hcount_in - act_x_q;
    dy = vcount_in - act_y_q;
    rom_addr_d = '0;
    if (hit_d) rom_addr_d = ADDR_WIDTH'(32'(dy) * CARD_W + 32'(dx));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_x_q       <= '0;
      sh_y_q       <= '0;
      sh_en_q      <= 1'b0;
      pend_q       <= 1'b0;
      act_x_q      <= '0;
      act_y_q      <= '0;
      act_en_q     <= 1'b0;
      vblnk_prev_q <= 1'b0;
      rom_addr_q   <= '0;
      hit1_q       <= 1'b0;
      hit2_q       <= 1'b0;
      hit3_q       <= 1'b0;
      pixel_q      <= '0;
    end else begin
      sh_x_q       <= sh_x_d;
      sh_y_q       <= sh_y_d;
      sh_en_q      <= sh_en_d;
      pend_q       <= pend_d;
      act_x_q      <= act_x_d;
      act_y_q      <= act_y_d;
      act_en_q     <= act_en_d;
      vblnk_prev_q <= vblnk_in;
      rom_addr_q   <= rom_addr_d;
      hit1_q       <= hit_d;
      hit2_q       <= hit1_q;
      hit3_q       <= hit2_q;
      pixel_q      <= rom_pixel;
    end
  end

  assign rom_addr = rom_addr_q;

  assign vga_in = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                    vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in,
                    rgb: rgb_in};

  vga_delay #(.N(3)) u_vga_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .vga_i (vga_in),
    .vga_o (vga_dly)
  );

`ifdef DRAW_CARD_TRANSPARENT_EN
  assign key_hit = (pixel_q == DATA_WIDTH'(TRANSPARENT_COLOR));
`else
  assign key_hit = 1'b0;
`endif

  // Blanking flags travel with the pixel, so the delayed copies gate the
  // same pixel the hit flag belongs to.
  assign draw = hit3_q && !vga_dly.hblnk && !vga_dly.vblnk && !key_hit;

  assign hcount_out = vga_dly.hcount;
  assign vcount_out = vga_dly.vcount;
  assign hsync_out  = vga_dly.hsync;
  assign vsync_out  = vga_dly.vsync;
  assign hblnk_out  = vga_dly.hblnk;
  assign vblnk_out  = vga_dly.vblnk;
  assign rgb_out    = draw ? pixel_q : vga_dly.rgb;

endmodule

// File: tb/tb_draw_card.sv
// tb_draw_card: scoreboard bench for draw_card. Stimulus pushes expected
// rom_addr (due 1 cycle later) and expected output pixel (due 3 cycles later);
// a monitor pops and compares on the falling edge.
module tb_draw_card;
  import draw_card_pkg::*;

`ifdef DRAW_CARD_TRANSPARENT_EN
  localparam bit TRANSP = 1'b1;
`else
  localparam bit TRANSP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] hc, vc;
  logic        hs, vs, hb, vb;
  logic [11:0] rgbi;
  logic [12:0] rom_addr;
  logic [11:0] rom_pixel = '0;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  draw_card_if pif ();

  draw_card dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hcount_in  (hc),
    .vcount_in  (vc),
    .hsync_in   (hs),
    .vsync_in   (vs),
    .hblnk_in   (hb),
    .vblnk_in   (vb),
    .rgb_in     (rgbi),
    .pos        (pif),
    .rom_addr   (rom_addr),
    .rom_pixel  (rom_pixel),
    .hcount_out (hcount_out),
    .vcount_out (vcount_out),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .hblnk_out  (hblnk_out),
    .vblnk_out  (vblnk_out),
    .rgb_out    (rgb_out)
  );

  always #5 clk = ~clk;

  // ROM model: synchronous read; address 5 holds the key colour.
  function automatic logic [11:0] rom_fn(input logic [12:0] a);
    if (a == 13'd5) return 12'hF0F;
    return a[11:0] ^ 12'hA00;
  endfunction

  always @(posedge clk) rom_pixel <= rom_fn(rom_addr);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; logic [12:0] addr; } addr_exp_t;
  typedef struct { int due; logic [37:0] px; } out_exp_t;
  addr_exp_t addr_q[$];
  out_exp_t  out_q[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Drive one pixel for the next edge; the expected output rgb is the ROM
  // model value when edraw, else the background.
  task automatic drive_px(input logic [10:0] h, input logic [10:0] v,
                          input logic hbk, input logic vbk, input logic [11:0] bg,
                          input logic [12:0] eaddr, input logic edraw);
    addr_exp_t ae;
    out_exp_t  oe;
    @(posedge clk);
    #1;
    hc = h; vc = v; hs = h[0]; vs = v[0]; hb = hbk; vb = vbk; rgbi = bg;
    if (rst_n) begin
      ae.due  = cyc + 1;
      ae.addr = eaddr;
      addr_q.push_back(ae);
      oe.due = cyc + 3;
      oe.px  = {h, v, h[0], v[0], hbk, vbk, (edraw ? rom_fn(eaddr) : bg)};
      out_q.push_back(oe);
    end
  endtask

  task automatic request(input logic [10:0] x, input logic [10:0] y, input logic en);
    pif.xpos = x; pif.ypos = y; pif.card_en = en; pif.pos_valid = 1'b1;
    drive_px(11'd0, 11'd0, 1'b0, 1'b0, 12'h0AA, 13'd0, 1'b0);
    pif.pos_valid = 1'b0;
  endtask

  task automatic vblank_pulse();
    drive_px(11'd0, 11'd0, 1'b0, 1'b1, 12'h555, 13'd0, 1'b0);
    drive_px(11'd0, 11'd0, 1'b0, 1'b0, 12'h556, 13'd0, 1'b0);
  endtask

  always @(negedge clk) begin : monitor
    addr_exp_t a;
    out_exp_t  o;
    logic [37:0] got;
    if (rst_n) begin
      while (addr_q.size() > 0 && addr_q[0].due <= cyc) begin
        a = addr_q.pop_front();
        checks++;
        if (a.due != cyc || rom_addr !== a.addr) begin
          errors++;
          $display("FAIL rom_addr due=%0d cyc=%0d got=%0d exp=%0d", a.due, cyc, rom_addr, a.addr);
        end
      end
      while (out_q.size() > 0 && out_q[0].due <= cyc) begin
        o = out_q.pop_front();
        got = {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out};
        checks++;
        if (o.due != cyc || got !== o.px) begin
          errors++;
          $display("FAIL pixel_out due=%0d cyc=%0d got h=%0d v=%0d rgb=%0h exp h=%0d v=%0d rgb=%0h (full got=%0h exp=%0h)",
                   o.due, cyc, got[37:27], got[26:16], got[11:0],
                   o.px[37:27], o.px[26:16], o.px[11:0], got, o.px);
        end
      end
    end
  end

  initial begin
    hc = 11'd77; vc = 11'd5; hs = 1'b1; vs = 1'b1; hb = 1'b0; vb = 1'b0; rgbi = 12'h123;
    pif.xpos = '0; pif.ypos = '0; pif.card_en = 1'b0; pif.pos_valid = 1'b0;

    // Reset state.
    #2;
    chk("rst_counts", {hcount_out, vcount_out}, 64'd0);
    chk("rst_flags_rgb", {hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out}, 64'd0);
    chk("rst_rom_addr", rom_addr, 64'd0);
    chk("rst_pos_ready", pif.pos_ready, 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Plain background pass-through.
    drive_px(11'd10, 11'd20, 1'b0, 1'b0, 12'h111, 13'd0, 1'b0);
    drive_px(11'd21, 11'd20, 1'b0, 1'b0, 12'h222, 13'd0, 1'b0);
    drive_px(11'd30, 11'd21, 1'b1, 1'b0, 12'h333, 13'd0, 1'b0);

    // Request mid-frame: no card yet.
    request(11'd100, 11'd50, 1'b1);
    chk("ready_drop", pif.pos_ready, 64'd0);
    drive_px(11'd100, 11'd50, 1'b0, 1'b0, 12'h444, 13'd0, 1'b0);
    drive_px(11'd163, 11'd50, 1'b0, 1'b0, 12'h445, 13'd0, 1'b0);

    // Second request while pending is ignored.
    request(11'd300, 11'd300, 1'b1);
    chk("ready_blocked", pif.pos_ready, 64'd0);

    vblank_pulse();
    chk("ready_after_commit", pif.pos_ready, 64'd1);

    // Next frame: card at (100,50).
    drive_px(11'd100, 11'd50, 1'b0, 1'b0, 12'h600, 13'd0, 1'b1);
    drive_px(11'd163, 11'd50, 1'b0, 1'b0, 12'h601, 13'd63, 1'b1);
    drive_px(11'd100, 11'd51, 1'b0, 1'b0, 12'h602, 13'd64, 1'b1);
    drive_px(11'd164, 11'd50, 1'b0, 1'b0, 12'h603, 13'd0, 1'b0);
    drive_px(11'd100, 11'd146, 1'b0, 1'b0, 12'h604, 13'd0, 1'b0);
    drive_px(11'd163, 11'd145, 1'b0, 1'b0, 12'h605, 13'd6143, 1'b1);
    drive_px(11'd99, 11'd50, 1'b0, 1'b0, 12'h606, 13'd0, 1'b0);
    drive_px(11'd110, 11'd50, 1'b1, 1'b0, 12'h607, 13'd10, 1'b0);
    drive_px(11'd105, 11'd50, 1'b0, 1'b0, 12'h608, 13'd5, !TRANSP);
    drive_px(11'd300, 11'd300, 1'b0, 1'b0, 12'h609, 13'd0, 1'b0);

    // Card hanging off the right edge.
    request(11'd1000, 11'd50, 1'b1);
    vblank_pulse();
    drive_px(11'd1000, 11'd50, 1'b0, 1'b0, 12'h700, 13'd0, 1'b1);
    drive_px(11'd1023, 11'd50, 1'b0, 1'b0, 12'h701, 13'd23, 1'b1);
    drive_px(11'd0, 11'd51, 1'b0, 1'b0, 12'h702, 13'd0, 1'b0);
    drive_px(11'd1010, 11'd50, 1'b0, 1'b0, 12'h703, 13'd10, 1'b1);
    drive_px(11'd1010, 11'd50, 1'b0, 1'b0, 12'h704, 13'd10, 1'b1);
    drive_px(11'd1010, 11'd50, 1'b0, 1'b0, 12'h705, 13'd10, 1'b1);

    // Reset mid-frame: in-flight pixels are discarded.
    #2;
    rst_n = 1'b0;
    addr_q.delete();
    out_q.delete();
    #1;
    chk("midrst_counts", {hcount_out, vcount_out}, 64'd0);
    chk("midrst_flags_rgb", {hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out}, 64'd0);
    chk("midrst_rom_addr", rom_addr, 64'd0);
    chk("midrst_pos_ready", pif.pos_ready, 64'd1);
    drive_px(11'd1010, 11'd50, 1'b0, 1'b0, 12'h706, 13'd0, 1'b0);
    drive_px(11'd1010, 11'd50, 1'b0, 1'b0, 12'h707, 13'd0, 1'b0);
    rst_n = 1'b1;
    drive_px(11'd1010, 11'd50, 1'b0, 1'b0, 12'h708, 13'd0, 1'b0);
    drive_px(11'd1011, 11'd51, 1'b0, 1'b0, 12'h709, 13'd0, 1'b0);
    vblank_pulse();
    drive_px(11'd1012, 11'd52, 1'b0, 1'b0, 12'h70A, 13'd0, 1'b0);

    repeat (8) @(posedge clk);
    #2;
    checks++;
    if (addr_q.size() != 0 || out_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d exp=0 pending entries", addr_q.size() + out_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
